// File: rtl/yin_tau_search.sv
// rtl/yin_tau_search.sv - YIN pitch-period selector over a streamed d'(tau) frame
// First sub-threshold tau, refined to its dip minimum; global-minimum fallback when nothing crosses.
module yin_tau_search #(
  parameter int DATA_W          = 60,
  parameter int TAU_W           = 8,
  parameter int MAX_TAU         = 40,
  parameter int MIN_TAU         = 2,
  parameter int THR_DEN         = 100,
  parameter int FALLBACK_GLOBAL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] avg,
  input  logic [7:0]        thr_num,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              busy,
  output logic              done,
  output logic [TAU_W-1:0]  tau_out,
  output logic              tau_found,
  output logic [DATA_W-1:0] min_val
);

  localparam int              THR_W    = DATA_W + 8;
  localparam int              CMP_W    = DATA_W + 32;
  localparam logic [TAU_W-1:0] LAST_IDX = TAU_W'(MAX_TAU - 1);
  localparam logic [TAU_W-1:0] MIN_IDX  = TAU_W'(MIN_TAU);
  localparam logic [31:0]     DEN      = 32'(THR_DEN);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    DESCEND,
    DRAIN,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [TAU_W-1:0]    idx, idx_nxt;
  logic [THR_W-1:0]    thr, thr_nxt;
  logic [DATA_W-1:0]   gmin, gmin_nxt;
  logic [TAU_W-1:0]    gtau, gtau_nxt;
  logic [DATA_W-1:0]   cval, cval_nxt;
  logic [TAU_W-1:0]    cand, cand_nxt;
  logic [TAU_W-1:0]    tau_out_nxt;
  logic                tau_found_nxt;
  logic [DATA_W-1:0]   min_val_nxt;

  logic                xfer;
  logic                counted;
  logic                last;
  logic                hit;
  logic [CMP_W-1:0]    scaled;

  assign s_ready = (state == SEARCH) || (state == DESCEND) || (state == DRAIN);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Threshold test by cross-multiplication at full width, so no divider and no truncation.
  assign xfer    = s_valid && s_ready;
  assign counted = (idx >= MIN_IDX);
  assign last    = (idx == LAST_IDX);
  assign scaled  = CMP_W'(s_data) * CMP_W'(DEN);
  assign hit     = counted && (scaled < CMP_W'(thr));

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    thr_nxt       = thr;
    gmin_nxt      = gmin;
    gtau_nxt      = gtau;
    cval_nxt      = cval;
    cand_nxt      = cand;
    tau_out_nxt   = tau_out;
    tau_found_nxt = tau_found;
    min_val_nxt   = min_val;

    case (state)
      IDLE: begin
        if (start) begin
          thr_nxt   = THR_W'(avg) * THR_W'(thr_num);
          idx_nxt   = '0;
          gmin_nxt  = '1;
          gtau_nxt  = '0;
          cval_nxt  = '0;
          cand_nxt  = '0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (xfer) begin
          idx_nxt = idx + TAU_W'(1);
          if (counted && (s_data < gmin)) begin
            gmin_nxt = s_data;
            gtau_nxt = idx;
          end
          if (hit) begin
            cand_nxt  = idx;
            cval_nxt  = s_data;
            state_nxt = DESCEND;
          end
        end
      end
      DESCEND: begin
        if (xfer) begin
          idx_nxt = idx + TAU_W'(1);
          if (s_data < cval) begin
            cand_nxt = idx;
            cval_nxt = s_data;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer) idx_nxt = idx + TAU_W'(1);
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The final beat overrides every other transition and commits the result.
    if (xfer && last) begin
      state_nxt = DONE;
      if ((state == SEARCH) && !hit) begin
        tau_found_nxt = 1'b0;
        if (FALLBACK_GLOBAL != 0) begin
          tau_out_nxt = gtau_nxt;
          min_val_nxt = gmin_nxt;
        end else begin
          tau_out_nxt = '0;
          min_val_nxt = '0;
        end
      end else begin
        tau_found_nxt = 1'b1;
        tau_out_nxt   = cand_nxt;
        min_val_nxt   = cval_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      thr       <= '0;
      gmin      <= '0;
      gtau      <= '0;
      cval      <= '0;
      cand      <= '0;
      tau_out   <= '0;
      tau_found <= 1'b0;
      min_val   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      thr       <= thr_nxt;
      gmin      <= gmin_nxt;
      gtau      <= gtau_nxt;
      cval      <= cval_nxt;
      cand      <= cand_nxt;
      tau_out   <= tau_out_nxt;
      tau_found <= tau_found_nxt;
      min_val   <= min_val_nxt;
    end
  end

endmodule

// File: tb/tb_yin_tau_search.sv
// tb/tb_yin_tau_search.sv - directed frame vectors for yin_tau_search
// Frames of 8 beats with hand-computed results, plus reset-mid-frame and start-in-DONE sequences.
module tb_yin_tau_search;

  localparam int DATA_W = 60;
  localparam int TAU_W  = 8;
  localparam int NV     = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] avg;
  logic [7:0]        thr_num;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              busy;
  logic              done;
  logic [TAU_W-1:0]  tau_out;
  logic              tau_found;
  logic [DATA_W-1:0] min_val;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0]       avg;
    logic [7:0]        thr;
    logic [0:7][63:0]  d;
    logic [7:0]        tau;
    logic [63:0]       minv;
    logic              found;
    logic              toggle;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  yin_tau_search #(
    .DATA_W(DATA_W), .TAU_W(TAU_W), .MAX_TAU(8), .MIN_TAU(1),
    .THR_DEN(100), .FALLBACK_GLOBAL(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .avg(avg), .thr_num(thr_num),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy),
    .done(done), .tau_out(tau_out), .tau_found(tau_found), .min_val(min_val)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input longint a, input int t,
                              input longint d0, input longint d1, input longint d2, input longint d3,
                              input longint d4, input longint d5, input longint d6, input longint d7,
                              input int tau, input longint mv, input int f, input int tg);
    vec_t r;
    r.avg = 64'(a);
    r.thr = 8'(t);
    r.d[0] = 64'(d0); r.d[1] = 64'(d1); r.d[2] = 64'(d2); r.d[3] = 64'(d3);
    r.d[4] = 64'(d4); r.d[5] = 64'(d5); r.d[6] = 64'(d6); r.d[7] = 64'(d7);
    r.tau = 8'(tau);
    r.minv = 64'(mv);
    r.found = (f != 0);
    r.toggle = (tg != 0);
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input string name, input bit start_in_done);
    int  i;
    int  cyc;
    bit  early;
    bit  tr;
    @(negedge clk);
    avg = v.avg[DATA_W-1:0];
    thr_num = v.thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_start"}, 64'(busy), 64'd1);
    i = 0; cyc = 0; early = 1'b0;
    while (i < 8 && cyc < 200) begin
      if (done) early = 1'b1;
      s_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = v.d[i][DATA_W-1:0];
      tr = s_valid && s_ready;
      @(negedge clk);
      if (tr) i++;
      cyc++;
    end
    s_valid = 1'b0;
    chk({name, ".beats_accepted"}, 64'(i), 64'd8);
    chk({name, ".no_early_done"}, 64'(early), 64'd0);
    chk({name, ".done"}, 64'(done), 64'd1);
    chk({name, ".tau_out"}, 64'(tau_out), 64'(v.tau));
    chk({name, ".min_val"}, 64'(min_val), v.minv);
    chk({name, ".tau_found"}, 64'(tau_found), 64'(v.found));
    chk({name, ".s_ready_done"}, 64'(s_ready), 64'd0);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".done_one_cycle"}, 64'(done), 64'd0);
    chk({name, ".idle_after"}, 64'(busy), 64'd0);
    chk({name, ".tau_held"}, 64'(tau_out), 64'(v.tau));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint h;
    bit     spurious;
    h = 64'h0800_0000_0000_0000;

    vecs[0]  = mk(1000, 10, 500, 400, 300, 90, 80, 85, 70, 200, 4, 80, 1, 0);
    vecs[1]  = mk(1000, 10, 500, 400, 300, 250, 260, 270, 280, 290, 3, 250, 0, 0);
    vecs[2]  = mk(1000, 10, 0, 500, 400, 300, 200, 150, 120, 110, 7, 110, 0, 0);
    vecs[3]  = mk(1000, 10, 900, 500, 95, 90, 80, 70, 60, 50, 7, 50, 1, 0);
    vecs[4]  = mk(1000, 10, 9, 500, 90, 90, 200, 200, 200, 200, 2, 90, 1, 0);
    vecs[5]  = mk(1000, 0, 9, 500, 90, 90, 200, 200, 200, 200, 2, 90, 0, 0);
    vecs[6]  = mk(0, 10, 9, 500, 90, 90, 200, 200, 200, 200, 2, 90, 0, 0);
    vecs[7]  = mk(1000, 10, 500, 400, 300, 250, 260, 270, 280, 99, 7, 99, 1, 0);
    vecs[8]  = mk(1000, 10, 500, 400, 300, 100, 150, 200, 200, 200, 3, 100, 0, 0);
    vecs[9]  = mk(1000, 10, 500, 400, 300, 90, 80, 85, 70, 200, 4, 80, 1, 1);
    // Threshold 200*2^58 needs more than DATA_W bits; only 2^59-1 crosses it.
    vecs[10] = mk(h / 2, 200, h, h, h, h - 1, h, h, h, h, 3, h - 1, 1, 0);

    reset = 1'b0; start = 1'b0; avg = '0; thr_num = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("reset.s_ready", 64'(s_ready), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.tau_out", 64'(tau_out), 64'd0);
    chk("reset.tau_found", 64'(tau_found), 64'd0);
    chk("reset.min_val", 64'(min_val), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      run_frame(vecs[k], $sformatf("vec%0d", k), k == 1);
    end

    // Abort a frame after four beats; nothing may complete and the next frame must be clean.
    @(negedge clk);
    avg = 1000; thr_num = 10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = vecs[0].d[i][DATA_W-1:0];
      @(negedge clk);
    end
    s_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset.s_ready", 64'(s_ready), 64'd0);
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    chk("midreset.tau_out", 64'(tau_out), 64'd0);
    reset = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = 60'd50;
      @(negedge clk);
      if (done || s_ready) spurious = 1'b1;
    end
    s_valid = 1'b0;
    chk("midreset.idle_quiet", 64'(spurious), 64'd0);
    run_frame(vecs[0], "after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
